instr_mem_banked: RTL and testbench

- Parametrised successor to the single-region instruction ROM.
- Two word-addressed regions: main program at MAIN_BASE and exception handler at EH_BASE.
- Synchronous 1-cycle read with a stall hold, and registered address-error detection.
- A byte-serial loader (driven by the UART receive path) writes programs at run time; the CPU fetch stage sits on the read side.

---
 rtl/instr_mem_banked.sv | 188 ++++++++++++++++++
 tb/tb_instr_mem_banked.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_banked.sv
// instr_mem_banked
//   Banked instruction memory with two word-addressed regions: a main program
//   region at MAIN_BASE and an exception-handler region at EH_BASE. The fetch
//   side is a registered 1-cycle read with stall hold and an address-error flag.
//   A byte-serial loader, driven from the UART receive path, writes programs at
//   run time. It fills the main region first and then continues into the
//   handler region.
//
// Ports
//   clk, reset      system clock; asynchronous active-high reset
//   PC              fetch byte address
//   fetch_en        1 = capture a new word this edge, 0 = hold Instr/addr_err
//   Instr           registered instruction word (0 on error or while loading)
//   addr_err        registered; PC misaligned or outside both regions
//   ld_start        pulse: begin a program load (honoured only when idle)
//   ld_byte_valid   ld_byte carries a loader byte this cycle
//   ld_byte         loader data byte, big-endian within each word
//   ld_end          pulse: terminate the load (a partial word is discarded)
//   ld_busy         loader is in LOAD
//   ld_done         one-cycle pulse when a load finishes
//   ld_count        words written by the current/last load
//   dbg_state       loader state (0 IDLE, 1 LOAD, 2 DONE)
//
// Loader handshake: there is no backpressure. A byte is consumed on every
// rising edge where ld_byte_valid=1 and the loader is in LOAD. Bytes presented
// in any other state are dropped.
//
// The memory arrays have no reset, so a program survives a reset. They hold
// zero at configuration.

module instr_mem_banked #(
  parameter logic [31:0] MAIN_BASE = 32'h0000_3000,
  parameter int          MAIN_AW   = 10,
  parameter logic [31:0] EH_BASE   = 32'h0000_4180,
  parameter int          EH_AW     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        fetch_en,
  output logic [31:0] Instr,
  output logic        addr_err,
  input  logic        ld_start,
  input  logic        ld_byte_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_end,
  output logic        ld_busy,
  output logic        ld_done,
  output logic [15:0] ld_count,
  output logic [1:0]  dbg_state
);

  localparam int MAIN_DEPTH = 1 << MAIN_AW;
  localparam int EH_DEPTH   = 1 << EH_AW;
  // Linear loader index of the final word; writing it ends the load.
  localparam logic [15:0] LAST_IDX = 16'(MAIN_DEPTH + EH_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_t;

  ld_state_t   state;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;

  logic [31:0] main_mem [MAIN_DEPTH];
  logic [31:0] eh_mem   [EH_DEPTH];

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Region decode. The subtraction is 33 bits wide, so a PC below the base
  // borrows into bit 32. That makes the offset huge, and it then fails the
  // upper-bound compare.
  // ---------------------------------------------------------------------------
  logic [32:0] main_off;
  logic [32:0] eh_off;
  logic        main_hit;
  logic        eh_hit;
  logic        fetch_err;
  logic [31:0] rd_word;

  always_comb begin
    main_off  = {1'b0, PC} - {1'b0, MAIN_BASE};
    eh_off    = {1'b0, PC} - {1'b0, EH_BASE};
    main_hit  = main_off < 33'(4 * MAIN_DEPTH);
    eh_hit    = eh_off   < 33'(4 * EH_DEPTH);
    fetch_err = (PC[1:0] != 2'b00) || !(main_hit || eh_hit);
    // Main takes priority if the two regions are configured to overlap.
    if (main_hit) rd_word = main_mem[MAIN_AW'(main_off >> 2)];
    else          rd_word = eh_mem[EH_AW'(eh_off >> 2)];
  end

  // ---------------------------------------------------------------------------
  // Loader write port. The linear write index is ld_count itself, because
  // each word written advances both.
  // ---------------------------------------------------------------------------
  logic        wr_en;
  logic        last_write;
  logic [31:0] wr_word;

  always_comb begin
    wr_en      = (state == LOAD) && ld_byte_valid && (byte_cnt == 2'd3);
    last_write = wr_en && (ld_count == LAST_IDX);
    wr_word    = {shift, ld_byte};
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (ld_count < 16'(MAIN_DEPTH)) main_mem[MAIN_AW'(ld_count)] <= wr_word;
      else eh_mem[EH_AW'(ld_count - 16'(MAIN_DEPTH))] <= wr_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ld_busy  <= 1'b0;
      ld_done  <= 1'b0;
      ld_count <= 16'd0;
      byte_cnt <= 2'd0;
      shift    <= 24'd0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start) begin
            state    <= LOAD;
            ld_busy  <= 1'b1;
            ld_count <= 16'd0;
            byte_cnt <= 2'd0;
            shift    <= 24'd0;
          end
        end
        LOAD: begin
          // The byte is consumed before ld_end is looked at, so a byte that
          // completes a word in the same cycle as ld_end is still written.
          if (ld_byte_valid) begin
            if (byte_cnt == 2'd3) begin
              ld_count <= ld_count + 16'd1;
              byte_cnt <= 2'd0;
            end else begin
              shift    <= {shift[15:0], ld_byte};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
          // A partial word left over here is not written. byte_cnt is
          // cleared on the next ld_start.
          if (ld_end || last_write) begin
            state   <= DONE;
            ld_busy <= 1'b0;
            ld_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch read register. It is forced to a quiet nop while a load is in
  // progress, so the CPU never sees a half-written program.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Instr    <= 32'd0;
      addr_err <= 1'b0;
    end else if (state == LOAD) begin
      Instr    <= 32'd0;
      addr_err <= 1'b0;
    end else if (fetch_en) begin
      if (fetch_err) begin
        Instr    <= 32'd0;
        addr_err <= 1'b1;
      end else begin
        Instr    <= rd_word;
        addr_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_banked.sv
// Testbench for instr_mem_banked (default parameters).
module tb_instr_mem_banked;

  localparam logic [31:0] MAIN_BASE  = 32'h0000_3000;
  localparam logic [31:0] EH_BASE    = 32'h0000_4180;
  localparam int          MAIN_WORDS = 1024;
  localparam int          EH_WORDS   = 1024;
  localparam int          ALL_WORDS  = MAIN_WORDS + EH_WORDS;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PC = 32'd0;
  logic        fetch_en = 1'b0;
  logic [31:0] Instr;
  logic        addr_err;
  logic        ld_start = 1'b0;
  logic        ld_byte_valid = 1'b0;
  logic [7:0]  ld_byte = 8'd0;
  logic        ld_end = 1'b0;
  logic        ld_busy;
  logic        ld_done;
  logic [15:0] ld_count;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  instr_mem_banked dut (
    .clk(clk), .reset(reset), .PC(PC), .fetch_en(fetch_en),
    .Instr(Instr), .addr_err(addr_err),
    .ld_start(ld_start), .ld_byte_valid(ld_byte_valid), .ld_byte(ld_byte),
    .ld_end(ld_end), .ld_busy(ld_busy), .ld_done(ld_done),
    .ld_count(ld_count), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  bit   [31:0] m_main [MAIN_WORDS];
  bit   [31:0] m_eh   [EH_WORDS];
  int          m_cnt;
  logic [7:0]  m_part [$];
  logic [31:0] exp_instr = 32'd0;
  logic        exp_err = 1'b0;

  function automatic void model_write(input int idx, input logic [31:0] w);
    if (idx < MAIN_WORDS) m_main[idx] = w;
    else m_eh[idx - MAIN_WORDS] = w;
  endfunction

  function automatic void model_fetch(input logic [31:0] pc, output logic [31:0] w, output logic e);
    longint unsigned a;
    a = longint'(pc);
    w = 32'd0;
    e = 1'b1;
    if (pc[1:0] == 2'b00) begin
      if (a >= MAIN_BASE && a < longint'(MAIN_BASE) + 4 * MAIN_WORDS) begin
        w = m_main[int'((a - MAIN_BASE) / 4)];
        e = 1'b0;
      end else if (a >= EH_BASE && a < longint'(EH_BASE) + 4 * EH_WORDS) begin
        w = m_eh[int'((a - EH_BASE) / 4)];
        e = 1'b0;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic en, input string name);
    PC = pc;
    fetch_en = en;
    tick();
    fetch_en = 1'b0;
    if (en) model_fetch(pc, exp_instr, exp_err);
    n_cmp++;
    if (Instr !== exp_instr || addr_err !== exp_err) begin
      n_bad++;
      $display("FAIL %s pc=%h en=%b: got Instr=%h addr_err=%b, want Instr=%h addr_err=%b",
               name, pc, en, Instr, addr_err, exp_instr, exp_err);
    end
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    m_cnt = 0;
    m_part.delete();
    n_cmp++;
    if (ld_busy !== 1'b1 || ld_done !== 1'b0 || ld_count !== 16'd0) begin
      n_bad++;
      $display("FAIL load_start: got busy=%b done=%b count=%0d, want 1 0 0", ld_busy, ld_done, ld_count);
    end
  endtask

  // Checks the one-cycle ld_done pulse and the final count once the load ends.
  task automatic check_done(input string name);
    n_cmp++;
    if (ld_done !== 1'b1 || ld_busy !== 1'b0 || ld_count !== 16'(m_cnt) || Instr !== 32'd0) begin
      n_bad++;
      $display("FAIL %s_done: got done=%b busy=%b count=%0d Instr=%h, want 1 0 %0d 00000000",
               name, ld_done, ld_busy, ld_count, Instr, m_cnt);
    end
    tick();
    n_cmp++;
    if (ld_done !== 1'b0 || dbg_state !== 2'd0 || ld_count !== 16'(m_cnt)) begin
      n_bad++;
      $display("FAIL %s_pulse: got done=%b state=%0d count=%0d, want 0 0 %0d",
               name, ld_done, dbg_state, ld_count, m_cnt);
    end
  endtask

  // Sends one byte, sometimes after an idle gap containing a stray ld_start.
  // Returns 1 when the load has ended.
  task automatic feed(input logic [7:0] b, input logic endf, output bit ended);
    if ($urandom_range(0, 3) == 0) begin
      ld_start = $urandom_range(0, 1);
      tick();
      ld_start = 1'b0;
    end
    PC = MAIN_BASE;
    fetch_en = $urandom_range(0, 1);
    ld_byte_valid = 1'b1;
    ld_byte = b;
    ld_end = endf;
    tick();
    ld_byte_valid = 1'b0;
    ld_end = 1'b0;
    fetch_en = 1'b0;
    exp_instr = 32'd0;
    exp_err = 1'b0;
    ended = endf;
    m_part.push_back(b);
    if (m_part.size() == 4) begin
      model_write(m_cnt, {m_part[0], m_part[1], m_part[2], m_part[3]});
      m_cnt++;
      m_part.delete();
      if (m_cnt == ALL_WORDS) ended = 1'b1;
    end
    if (ended) begin
      m_part.delete();
      check_done("feed");
    end else begin
      n_cmp++;
      if (ld_busy !== 1'b1 || ld_done !== 1'b0 || ld_count !== 16'(m_cnt) ||
          Instr !== 32'd0 || addr_err !== 1'b0) begin
        n_bad++;
        $display("FAIL feed: got busy=%b done=%b count=%0d Instr=%h err=%b, want 1 0 %0d 00000000 0",
                 ld_busy, ld_done, ld_count, Instr, addr_err, m_cnt);
      end
    end
  endtask

  task automatic end_load();
    ld_end = 1'b1;
    tick();
    ld_end = 1'b0;
    m_part.delete();
    check_done("end");
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (Instr !== 32'd0 || addr_err !== 1'b0 || ld_busy !== 1'b0 || ld_done !== 1'b0 ||
        ld_count !== 16'd0 || dbg_state !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_values: got Instr=%h err=%b busy=%b done=%b count=%0d state=%0d, want all zero",
               Instr, addr_err, ld_busy, ld_done, ld_count, dbg_state);
    end
    fetch(MAIN_BASE, 1'b1, "empty_main");
    fetch(EH_BASE + 32'd8, 1'b1, "empty_eh");
  endtask

  task automatic test_basic_load();
    logic [7:0] prog [8];
    bit ended;
    prog = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    start_load();
    foreach (prog[i]) feed(prog[i], 1'b0, ended);
    end_load();
    n_cmp++;
    if (ld_count !== 16'd2) begin
      n_bad++;
      $display("FAIL basic_count: got %0d, want 2", ld_count);
    end
    fetch(MAIN_BASE, 1'b1, "basic_w0");
    n_cmp++;
    if (Instr !== 32'h2408_0005) begin
      n_bad++;
      $display("FAIL basic_literal: got %h, want 24080005", Instr);
    end
    fetch(MAIN_BASE + 32'd4, 1'b1, "basic_w1");
  endtask

  task automatic test_ignored_inputs();
    // Bytes and ld_end while idle must change nothing.
    ld_byte_valid = 1'b1;
    ld_byte = 8'hAA;
    ld_end = 1'b1;
    repeat (4) tick();
    ld_byte_valid = 1'b0;
    ld_end = 1'b0;
    n_cmp++;
    if (ld_busy !== 1'b0 || ld_done !== 1'b0 || ld_count !== 16'(m_cnt)) begin
      n_bad++;
      $display("FAIL idle_ignore: got busy=%b done=%b count=%0d, want 0 0 %0d",
               ld_busy, ld_done, ld_count, m_cnt);
    end
    fetch(MAIN_BASE, 1'b1, "idle_ignore_mem");
  endtask

  task automatic test_spill();
    bit ended;
    start_load();
    for (int w = 0; w < MAIN_WORDS + 1; w++)
      for (int k = 0; k < 4; k++) feed(8'(w), 1'b0, ended);
    end_load();
    fetch(EH_BASE, 1'b1, "spill_eh0");
    n_cmp++;
    if (Instr !== 32'h0000_0000) begin
      n_bad++;
      $display("FAIL spill_literal: got %h, want 00000000", Instr);
    end
    fetch(MAIN_BASE + 32'h3FC, 1'b1, "spill_main255");
    fetch(MAIN_BASE + 32'hFFC, 1'b1, "spill_main_last");
    fetch(EH_BASE + 32'd4, 1'b1, "spill_eh1");
  endtask

  task automatic test_full_load();
    bit ended;
    logic [31:0] pc;
    int sent;
    start_load();
    ended = 1'b0;
    sent = 0;
    while (!ended && sent < 4 * ALL_WORDS + 8) begin
      feed(8'($urandom), 1'b0, ended);
      sent++;
    end
    n_cmp++;
    if (sent !== 4 * ALL_WORDS || ld_count !== 16'(ALL_WORDS)) begin
      n_bad++;
      $display("FAIL full_autostop: got bytes=%0d count=%0d, want %0d %0d",
               sent, ld_count, 4 * ALL_WORDS, ALL_WORDS);
    end
    fetch(EH_BASE + 32'hFFC, 1'b1, "full_eh_last");
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: pc = MAIN_BASE + 32'(4 * $urandom_range(0, MAIN_WORDS - 1));
        1: pc = EH_BASE + 32'(4 * $urandom_range(0, EH_WORDS - 1));
        2: pc = 32'($urandom_range(32'h2F00, 32'h5200));
        default: pc = $urandom;
      endcase
      fetch(pc, 1'($urandom_range(0, 3) != 0), "full_random");
    end
  endtask

  task automatic test_errors();
    fetch(MAIN_BASE + 32'd8, 1'b1, "err_pre_valid");
    fetch(32'h0000_3002, 1'b1, "err_misaligned");
    n_cmp++;
    if (addr_err !== 1'b1 || Instr !== 32'd0) begin
      n_bad++;
      $display("FAIL err_literal: got err=%b Instr=%h, want 1 00000000", addr_err, Instr);
    end
    fetch(MAIN_BASE + 32'd8, 1'b0, "err_hold_after_err");
    fetch(32'h0000_6000, 1'b1, "err_outside");
    fetch(32'h0000_4000, 1'b1, "err_gap");
    fetch(32'h0000_2FFC, 1'b1, "err_below_main");
    fetch(32'h0000_5180, 1'b1, "err_above_eh");
    fetch(32'h0000_517C, 1'b1, "eh_top_word");
    fetch(32'h0000_5000, 1'b1, "eh_inner_word");
    fetch(32'h0000_6000, 1'b0, "hold_after_valid");
    fetch(32'hFFFF_FFFC, 1'b1, "err_wrap");
  endtask

  task automatic test_end_coincide();
    bit ended;
    start_load();
    for (int i = 0; i < 6; i++) feed(8'($urandom), 1'b0, ended);
    feed(8'h77, 1'b1, ended);
    n_cmp++;
    if (ld_count !== 16'd1) begin
      n_bad++;
      $display("FAIL end_partial_count: got %0d, want 1", ld_count);
    end
    fetch(MAIN_BASE + 32'd4, 1'b1, "end_partial_not_written");
    start_load();
    for (int i = 0; i < 7; i++) feed(8'($urandom), 1'b0, ended);
    feed(8'h5A, 1'b1, ended);
    n_cmp++;
    if (ld_count !== 16'd2) begin
      n_bad++;
      $display("FAIL end_full_count: got %0d, want 2", ld_count);
    end
    fetch(MAIN_BASE, 1'b1, "end_full_w0");
    fetch(MAIN_BASE + 32'd4, 1'b1, "end_full_w1");
    fetch(MAIN_BASE + 32'd8, 1'b1, "end_full_w2_untouched");
  endtask

  task automatic test_reset_midload();
    bit ended;
    start_load();
    for (int i = 0; i < 5; i++) feed(8'($urandom), 1'b0, ended);
    #1 reset = 1'b1;
    #1;
    m_cnt = 0;
    m_part.delete();
    exp_instr = 32'd0;
    exp_err = 1'b0;
    n_cmp++;
    if (ld_busy !== 1'b0 || ld_count !== 16'd0 || ld_done !== 1'b0 || dbg_state !== 2'd0 || Instr !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_midload: got busy=%b count=%0d done=%b state=%0d Instr=%h, want 0 0 0 0 00000000",
               ld_busy, ld_count, ld_done, dbg_state, Instr);
    end
    #2 reset = 1'b0;
    tick();
    fetch(MAIN_BASE, 1'b1, "reset_retained_w0");
    fetch(MAIN_BASE + 32'd4, 1'b1, "reset_w1_unchanged");
    n_cmp++;
    if (ld_busy !== 1'b0 || ld_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_stays_idle: got busy=%b count=%0d, want 0 0", ld_busy, ld_count);
    end
  endtask

  // ---------------- sequencer / report ----------------
  initial begin
    m_cnt = 0;
    test_reset();
    test_basic_load();
    test_ignored_inputs();
    test_errors();
    test_spill();
    test_full_load();
    test_errors();
    test_end_coincide();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, want run to finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "time limit");
  end

endmodule
